// File: rtl/apb_protocol_checker.sv
// apb_protocol_checker: passive APB3 protocol checker with saturating read/write/slave-error counters.
// Define APB_CHECKER_TIMEOUT_EN to add the ACCESS wait-state timeout check (code 6).
module apb_protocol_checker #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SEL     = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic                       penable,
  input  logic [NUM_SEL-1:0]         psel,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pslverr,
  input  logic                       err_clr,
  output logic                       err_valid,
  output logic [2:0]                 err_code,
  output logic [$clog2(NUM_SEL)-1:0] err_slave,
  output logic [7:0]                 err_status,
  output logic [CNT_W-1:0]           wr_count,
  output logic [CNT_W-1:0]           rd_count,
  output logic [CNT_W-1:0]           slverr_count,
  output logic                       busy
);
  localparam int SW = $clog2(NUM_SEL);
  typedef enum logic [1:0] {SYNC, IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NUM_SEL-1:0] sel_q, sel_d;
  logic wr_q, wr_d, err_valid_q, err_valid_d, busy_q, busy_d;
  logic [2:0] err_code_q, err_code_d;
  logic [SW-1:0] err_slave_q, err_slave_d, low_sel;
  logic [7:0] err_status_q, err_status_d, errs;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, se_cnt_q, se_cnt_d;
  logic multi, acc, done, timeout, unused;
  assign unused = ^{prdata, TIMEOUT_CYC != 0};
  assign multi = state_q != SYNC && (psel & (psel - 1'b1)) != '0;
  // SETUP state sees the bus's first access-phase cycle, so a zero-wait transfer completes there
  assign acc = state_q == ACCESS || (state_q == SETUP && penable && psel == sel_q);
  always_comb begin
    low_sel = '0;
    for (int i = NUM_SEL - 1; i >= 0; i--) if (psel[i]) low_sel = SW'(i);
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    errs    = '0;
    done    = 1'b0;
    case (state_q)
      SYNC: if (psel == '0) state_d = IDLE;
      IDLE: if (psel != '0) begin
        if (penable) errs[2] = 1'b1;
        else begin
          state_d = SETUP;
          addr_d  = paddr;
          wdata_d = pwdata;
          sel_d   = psel;
          wr_d    = pwrite;
        end
      end
      SETUP: if (!acc) begin
        errs[5] = 1'b1;
        state_d = IDLE;
      end
      default: if (!penable || psel == '0) begin
        errs[4] = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (acc) begin
      errs[3] = paddr != addr_q || pwrite != wr_q || psel != sel_q || (wr_q && pwdata != wdata_q);
      if (!errs[4]) begin
        done    = pready;
        state_d = pready ? IDLE : ACCESS;
      end
    end
    if (multi) begin
      errs[1] = 1'b1;
      done    = 1'b0;
      state_d = IDLE;
    end
    errs[6]      = timeout;
    err_valid_d  = |errs;
    err_code_d   = errs[1] ? 3'd1 : errs[2] ? 3'd2 : errs[3] ? 3'd3 : errs[4] ? 3'd4 :
                   errs[5] ? 3'd5 : errs[6] ? 3'd6 : 3'd0;
    err_slave_d  = |errs ? low_sel : '0;
    err_status_d = (err_clr ? 8'h00 : err_status_q) | errs;
    wr_cnt_d     = (done && wr_q && wr_cnt_q != '1) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    rd_cnt_d     = (done && !wr_q && rd_cnt_q != '1) ? rd_cnt_q + 1'b1 : rd_cnt_q;
    se_cnt_d     = (done && pslverr && se_cnt_q != '1) ? se_cnt_q + 1'b1 : se_cnt_q;
    busy_d       = state_d == SETUP || state_d == ACCESS;
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= SYNC;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      wr_q         <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_slave_q  <= '0;
      err_status_q <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      se_cnt_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      wr_q         <= wr_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_slave_q  <= err_slave_d;
      err_status_q <= err_status_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      se_cnt_q     <= se_cnt_d;
      busy_q       <= busy_d;
    end
  end
`ifdef APB_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_q, wait_d;
  logic fired_q, fired_d, stay;
  assign stay    = acc && state_d == ACCESS;
  assign timeout = wait_q == TW'(TIMEOUT_CYC) && !fired_q;
  always_comb begin
    wait_d  = !stay ? '0 : wait_q == TW'(TIMEOUT_CYC) ? wait_q : wait_q + 1'b1;
    fired_d = stay && (fired_q || timeout);
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      fired_q <= fired_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_slave    = err_slave_q;
  assign err_status   = err_status_q;
  assign wr_count     = wr_cnt_q;
  assign rd_count     = rd_cnt_q;
  assign slverr_count = se_cnt_q;
  assign busy         = busy_q;
endmodule
